// File: rtl/output_dma_burst_engine.sv
// Word-wide output DMA: BRAM -> AXI4 INCR write bursts, split at MAX_BURST_LEN and 4 KB.
// Optional OUTPUT_DMA_PERF_CNT_EN adds perf_cycles / perf_stall counters.
module output_dma_burst_engine #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [ADDR_WIDTH-1:0]   dst_addr,
  input  logic [15:0]             beat_count,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH-1:0]   bram_addr,
  output logic                    bram_rd_en,
  input  logic [DATA_WIDTH-1:0]   bram_rd_data,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
`ifdef OUTPUT_DMA_PERF_CNT_EN
  ,
  output logic [31:0]             perf_cycles,
  output logic [31:0]             perf_stall
`endif
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SIZE  = $clog2(BYTES);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   src_q, src_d;
  logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
  logic [15:0]             rem_q, rem_d;
  logic [15:0]             total_q, total_d;
  logic [15:0]             issued_q, issued_d;
  logic [7:0]              awlen_q, awlen_d;
  logic [7:0]              beat_q, beat_d;
  logic                    error_q, error_d;
  logic                    inflight_q, inflight_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];

  logic                    active;
  logic                    rd_en;
  logic                    pop;
  logic                    flush;
  logic                    fifo_valid;
  logic [ADDR_WIDTH-1:0]   burst_bytes;
  logic [15:0]             burst_beats;

  // Beats-1 of the next burst: limited by remaining beats, max length and the 4 KB page end.
  function automatic logic [7:0] calc_awlen(input logic [11:0] dst_lo, input logic [15:0] rem);
    logic [16:0] len;
    logic [16:0] room;
    len = {1'b0, rem};
    if (len > 17'(MAX_BURST_LEN)) len = 17'(MAX_BURST_LEN);
    room = 17'((13'h1000 - {1'b0, dst_lo}) >> SIZE);
    if (room < len) len = room;
    return 8'(len - 17'd1);
  endfunction

  assign burst_beats = 16'({1'b0, awlen_q} + 9'd1);
  assign burst_bytes = ADDR_WIDTH'({1'b0, awlen_q} + 9'd1) << SIZE;
  assign active      = (state_q == S_AW) || (state_q == S_W) || (state_q == S_B);
  assign fifo_valid  = (count_q != '0);
  assign rd_en       = active && ((count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH)) &&
                       (issued_q < total_q);
  assign pop         = (state_q == S_W) && fifo_valid && wready;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    total_d    = total_q;
    issued_d   = issued_q;
    awlen_d    = awlen_q;
    beat_d     = beat_q;
    error_d    = error_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = rd_en;
    flush      = 1'b0;

    if (rd_en) begin
      src_d    = src_q + ADDR_WIDTH'(1);
      issued_d = issued_q + 16'd1;
    end
    if (inflight_q) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)        rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(inflight_q) - CW'(pop);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (beat_count == 16'd0) begin
            state_d = S_DONE;
          end else begin
            src_d    = src_addr;
            dst_d    = dst_addr;
            rem_d    = beat_count;
            total_d  = beat_count;
            issued_d = 16'd0;
            beat_d   = 8'd0;
            awlen_d  = calc_awlen(dst_addr[11:0], beat_count);
            state_d  = S_AW;
          end
        end
      end
      S_AW: begin
        if (awready) state_d = S_W;
      end
      S_W: begin
        if (pop) begin
          if (beat_q == awlen_q) begin
            beat_d  = 8'd0;
            state_d = S_B;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_B: begin
        if (bvalid) begin
          if (bresp != 2'b00) begin
            error_d = 1'b1;
            flush   = 1'b1;
            state_d = S_DONE;
          end else begin
            dst_d = dst_q + burst_bytes;
            rem_d = rem_q - burst_beats;
            if (rem_d != 16'd0) begin
              awlen_d = calc_awlen(dst_d[11:0], rem_d);
              state_d = S_AW;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An error abandons prefetched data and the read still in flight.
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      total_q    <= '0;
      issued_q   <= '0;
      awlen_q    <= '0;
      beat_q     <= '0;
      error_q    <= 1'b0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      total_q    <= total_d;
      issued_q   <= issued_d;
      awlen_q    <= awlen_d;
      beat_q     <= beat_d;
      error_q    <= error_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (inflight_q) fifo_mem[wr_ptr_q] <= bram_rd_data;
  end

  assign busy       = active;
  assign done       = (state_q == S_DONE);
  assign error      = error_q;
  assign bram_addr  = src_q;
  assign bram_rd_en = rd_en;
  assign awaddr     = dst_q;
  assign awlen      = awlen_q;
  assign awsize     = 3'(SIZE);
  assign awburst    = 2'b01;
  assign awvalid    = (state_q == S_AW);
  assign wvalid     = (state_q == S_W) && fifo_valid;
  assign wdata      = wvalid ? fifo_mem[rd_ptr_q] : '0;
  assign wstrb      = wvalid ? '1 : '0;
  assign wlast      = wvalid && (beat_q == awlen_q);
  assign bready     = (state_q == S_B);

`ifdef OUTPUT_DMA_PERF_CNT_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stall_d  = perf_stall_q;
    if ((state_q == S_IDLE) && start) begin
      perf_cycles_d = '0;
      perf_stall_d  = '0;
    end else begin
      if (busy) perf_cycles_d = perf_cycles_q + 32'd1;
      if (wvalid && !wready) perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_output_dma_burst_engine.sv
// Self-checking bench for output_dma_burst_engine: table rows, random transfers, mid-transfer reset.
module tb_output_dma_burst_engine;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MBL = 16;
  localparam int unsigned FD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [15:0]   beat_count = '0;
  logic          busy, done, error;
  logic [AW-1:0] bram_addr;
  logic          bram_rd_en;
  logic [DW-1:0] bram_rd_data = '0;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wlast, wvalid;
  logic          wready = 1'b0;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0;
  logic          bready;

  output_dma_burst_engine #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST_LEN(MBL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .beat_count(beat_count), .busy(busy), .done(done), .error(error),
    .bram_addr(bram_addr), .bram_rd_en(bram_rd_en), .bram_rd_data(bram_rd_data),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Slave behaviour knobs, written only by the stimulus process.
  int unsigned k_aw_dly = 0;
  int unsigned k_w_pct = 100;
  bit          k_err1 = 1'b0;
  logic [31:0] k_salt = '0;

  // Per-transfer observations, written only by the monitor process.
  logic [31:0] rec_awaddr [64];
  logic [7:0]  rec_awlen [64];
  logic [31:0] rec_wdata [256];
  bit          rec_wlast [256];
  int aw_n, beat_n, done_n, busy_n, rd_n, b_n, max_out, prot_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // BRAM model: word at address a reads as a ^ salt, one cycle after the strobe; garbage otherwise.
  initial begin
    logic          en;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      en = bram_rd_en;
      a  = bram_addr;
      @(posedge clk);
      #1;
      bram_rd_data = (en === 1'b1) ? (a ^ k_salt) : $urandom;
    end
  end

  // AXI slave plus monitor. Ready/valid for the next edge is decided first, then the
  // handshakes that edge will perform are recorded.
  initial begin
    bit          b_pending, aw_hold, prev_stall;
    int unsigned aw_wait;
    logic [31:0] held_addr, prev_wdata;
    logic [7:0]  held_len;
    b_pending = 0; aw_hold = 0; prev_stall = 0; aw_wait = 0;
    held_addr = '0; held_len = '0; prev_wdata = '0;
    aw_n = 0; beat_n = 0; done_n = 0; busy_n = 0; rd_n = 0; b_n = 0; max_out = 0; prot_err = 0;
    forever begin
      @(negedge clk);
      if (start === 1'b1 || rst === 1'b1) begin
        aw_n = 0; beat_n = 0; done_n = 0; busy_n = 0; rd_n = 0; b_n = 0;
        max_out = 0; prot_err = 0; b_pending = 0; aw_hold = 0; prev_stall = 0; aw_wait = 0;
      end
      awready = (awvalid === 1'b1) && (aw_wait >= k_aw_dly);
      wready  = ($urandom_range(99) < k_w_pct);
      bvalid  = b_pending;
      bresp   = (k_err1 && b_n == 0) ? 2'b10 : 2'b00;

      if (aw_hold && (awvalid !== 1'b1 || awaddr !== held_addr || awlen !== held_len)) prot_err++;
      if (prev_stall && (wvalid !== 1'b1 || wdata !== prev_wdata)) prot_err++;

      aw_hold = 0;
      if (awvalid === 1'b1 && awready) begin
        if (aw_n < 64) begin rec_awaddr[aw_n] = awaddr; rec_awlen[aw_n] = awlen; end
        aw_n++;
        aw_wait = 0;
        if (awsize !== 3'd2 || awburst !== 2'b01) prot_err++;
      end else if (awvalid === 1'b1) begin
        aw_wait++;
        aw_hold = 1; held_addr = awaddr; held_len = awlen;
      end
      if (wvalid === 1'b1 && wready) begin
        if (beat_n < 256) begin rec_wdata[beat_n] = wdata; rec_wlast[beat_n] = wlast; end
        beat_n++;
        if (wstrb !== 4'hF) prot_err++;
        if (wlast === 1'b1) b_pending = 1;
      end
      prev_stall = (wvalid === 1'b1) && !wready;
      prev_wdata = wdata;
      if (bvalid && bready === 1'b1) begin b_pending = 0; b_n++; end
      if (bram_rd_en === 1'b1) rd_n++;
      if (rd_n - beat_n > max_out) max_out = rd_n - beat_n;
      if (done === 1'b1) done_n++;
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1 && busy === 1'b1) prot_err++;
    end
  end

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"}, {busy, done, error, bram_rd_en, awvalid, wvalid, wlast, bready}, 0);
    chk({tag, "_bram_addr"}, bram_addr, 0);
    chk({tag, "_awaddr"}, awaddr, 0);
    chk({tag, "_awlen"}, awlen, 0);
    chk({tag, "_awsize"}, awsize, 2);
    chk({tag, "_awburst"}, awburst, 1);
    chk({tag, "_wdata_wstrb"}, {wdata, wstrb}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2; rst = 1'b1;
    @(negedge clk); #2; rst = 1'b0;
  endtask

  task automatic run_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                          input int unsigned cnt, input int unsigned aw_dly, input int unsigned w_pct,
                          input bit err1, input logic [31:0] salt, input int exp_nb_tab,
                          input bit exp_err);
    logic [31:0]  e_addr [$];
    int unsigned  e_len [$];
    int unsigned  rem, room, n, total, last_at, data_bad, last_bad, first_bad;
    logic [31:0]  a, exp_w;
    bit           got_done;

    // Reference burst plan straight from the splitting rules.
    rem = cnt; a = dst; total = 0;
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / 4;
      n = rem;
      if (n > MBL) n = MBL;
      if (n > room) n = room;
      e_addr.push_back(a); e_len.push_back(n);
      total += n;
      if (err1) break;
      a += n * 4; rem -= n;
    end

    k_aw_dly = aw_dly; k_w_pct = w_pct; k_err1 = err1; k_salt = salt;
    @(negedge clk); #2;
    src_addr = src; dst_addr = dst; beat_count = cnt[15:0]; start = 1'b1;
    @(negedge clk); #2;
    start = 1'b0;
    if (cnt == 0) chk({tag, "_done_next"}, {done, busy}, 2'b10);
    else          chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_error_cleared"}, error, 0);

    got_done = (done === 1'b1);
    for (int i = 0; i < 5000 && !got_done; i++) begin
      @(negedge clk); #2;
      got_done = (done === 1'b1);
    end
    if (!got_done) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_done required=done_within_5000_cycles", tag);
      do_reset();
      return;
    end
    repeat (3) @(negedge clk);
    #2;

    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_error"}, error, exp_err);
    if (exp_nb_tab >= 0) chk({tag, "_bursts_tab"}, aw_n, exp_nb_tab);
    chk({tag, "_bursts"}, aw_n, e_addr.size());
    for (int b = 0; b < e_addr.size() && b < aw_n && b < 64; b++) begin
      chk($sformatf("%s_awaddr%0d", tag, b), rec_awaddr[b], e_addr[b]);
      chk($sformatf("%s_awlen%0d", tag, b), rec_awlen[b], e_len[b] - 1);
    end
    chk({tag, "_beats"}, beat_n, total);

    data_bad = 0; last_bad = 0; first_bad = 0; last_at = 0;
    for (int b = 0; b < e_len.size(); b++) begin
      for (int k = 0; k < e_len[b]; k++) begin
        if (last_at < beat_n && last_at < 256) begin
          exp_w = (src + last_at) ^ salt;
          if (rec_wdata[last_at] !== exp_w) begin
            if (data_bad == 0) first_bad = last_at;
            data_bad++;
          end
          if (rec_wlast[last_at] !== (k == e_len[b] - 1)) last_bad++;
        end
        last_at++;
      end
    end
    checks++;
    if (data_bad != 0) begin
      failures++;
      $display("FAIL %s_wdata actual=%0d_bad_beats_first_at_%0d required=0_bad", tag, data_bad, first_bad);
    end
    chk({tag, "_wlast_pattern_bad"}, last_bad, 0);
    if (!err1) chk({tag, "_reads"}, rd_n, cnt);
    chk({tag, "_outstanding_over_depth"}, (max_out > FD), 0);
    chk({tag, "_protocol_violations"}, prot_err, 0);
    if (cnt == 0) chk({tag, "_busy_cycles"}, busy_n, 0);
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int unsigned cnt;
    int unsigned aw_dly;
    int unsigned w_pct;
    bit          err1;
    int          exp_nb;
    bit          exp_err;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{32'h0,   32'h1000, 40, 0, 100, 1'b0, 3, 1'b0};
    tbl[1] = '{32'h0,   32'h1FF8,  6, 0, 100, 1'b0, 2, 1'b0};
    tbl[2] = '{32'h0,   32'h0,     0, 0, 100, 1'b0, 0, 1'b0};
    tbl[3] = '{32'h0,   32'h1000, 20, 5,  50, 1'b0, 2, 1'b0};
    tbl[4] = '{32'h0,   32'h1000, 40, 0, 100, 1'b1, 1, 1'b1};
    tbl[5] = '{32'h100, 32'h3000,  1, 2,  70, 1'b0, 1, 1'b0};
    tbl[6] = '{32'h20,  32'h0FC0, 40, 0, 100, 1'b0, 3, 1'b0};
    tbl[7] = '{32'h7,   32'h1FFC, 17, 1,  30, 1'b0, 2, 1'b0};

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    check_reset_outs("reset");

    for (int i = 0; i < 8; i++)
      run_xfer($sformatf("vec%0d", i), tbl[i].src, tbl[i].dst, tbl[i].cnt, tbl[i].aw_dly,
               tbl[i].w_pct, tbl[i].err1, 32'h0, tbl[i].exp_nb, tbl[i].exp_err);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] d;
      int unsigned c;
      bit e;
      d = ($urandom_range(0, 7) << 12);
      if ($urandom_range(1)) d += 4096 - 4 * $urandom_range(1, 24);
      else                   d += 4 * $urandom_range(0, 1023);
      c = $urandom_range(1, 70);
      e = ($urandom_range(7) == 0);
      run_xfer($sformatf("rnd%0d", i), $urandom_range(0, 4095), d, c, $urandom_range(0, 3),
               $urandom_range(20, 100), e, $urandom, -1, e);
    end

    // Reset during the W phase of the second burst, then a short clean transfer.
    begin
      bit hit;
      k_aw_dly = 0; k_w_pct = 100; k_err1 = 1'b0; k_salt = '0;
      @(negedge clk); #2;
      src_addr = '0; dst_addr = 32'h1000; beat_count = 16'd40; start = 1'b1;
      @(negedge clk); #2;
      start = 1'b0;
      hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
        @(negedge clk); #2;
        hit = (aw_n == 2) && (wvalid === 1'b1);
      end
      chk("midrst_reached_w2", hit, 1);
      @(negedge clk); #2; rst = 1'b1;
      @(negedge clk); #2; rst = 1'b0;
      check_reset_outs("midrst");
      run_xfer("after_rst", 32'h40, 32'h5000, 4, 0, 100, 1'b0, 32'h0, 1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
